frog_move_ctrl: RTL and testbench
=================================

FROG_MOVE_CTRL -- requirements
Module: frog_move_ctrl

Interface
REQ-001 SHALL have parameter START_X, default 10'd304, frog spawn column (pixels).
REQ-002 SHALL have parameter START_Y, default 10'd448, frog spawn row (pixels).
REQ-003 SHALL have parameter STEP, default 10'd32, hop distance in pixels (equal to frog_size).
REQ-004 SHALL have parameter HOP_FRAMES, default 8, frames per hop; STEP SHALL divide evenly by HOP_FRAMES.
REQ-005 SHALL have parameter X_MAX, default 10'd608, largest legal frog_x; Y_MAX, default 10'd448, largest legal frog_y; the minimum for both is 0.
REQ-006 SHALL have parameter DEATH_FRAMES, default 60, frames spent in DEAD before respawn.
REQ-007 clk  input  1  system clock; the one clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 btn_up, btn_down, btn_left, btn_right  input  1 each  synchronised button levels.
REQ-010 frame_tick  input  1  one-cycle pulse per video frame.
REQ-011 hit  input  1  collision level from the playfield; sampled only in IDLE/HOP.
REQ-012 frog_x, frog_y  output  10 each  frog top-left position, drives frog_gen.
REQ-013 facing  output  2  00 up, 01 down, 10 left, 11 right.
REQ-014 hopping  output  1  high while in HOP.
REQ-015 dead  output  1  high while in DEAD.
REQ-016 hop_done  output  1  one-cycle pulse on the cycle the state leaves HOP.

Function
REQ-017 Press = rising edge of a button level (registered previous level); held buttons SHALL NOT repeat.
REQ-018 Simultaneous presses in one cycle: priority up > down > left > right; the others SHALL be discarded.
REQ-019 FSM states: IDLE, HOP, DEAD.
REQ-020 IDLE + press: facing SHALL update on the next edge; if the target (position +/- STEP) lies within [0, max], go to HOP; else stay in IDLE with the position unchanged.
REQ-021 HOP: each frame_tick SHALL move the position STEP/HOP_FRAMES pixels toward the target; the frame counter SHALL count 0..HOP_FRAMES-1.
REQ-022 HOP: after the HOP_FRAMES-th tick, the position SHALL equal the target exactly, hop_done SHALL pulse, and the state SHALL return to IDLE.
REQ-023 Position arithmetic SHALL be 10-bit unsigned; the bounds check SHALL be done before subtraction so no wrap-around occurs (for example, x=0 with left never yields 1023).
REQ-024 hit high in IDLE or HOP SHALL enter DEAD on the next edge; hit has priority over a press and over hop completion in the same cycle; hop_done SHALL NOT pulse.
REQ-025 DEAD: the position SHALL freeze; presses SHALL be ignored; after DEATH_FRAMES frame_ticks, frog_x/frog_y SHALL load START_X/START_Y, facing SHALL load 00, and the state SHALL go to IDLE.
REQ-026 Without frame_tick, HOP and DEAD SHALL hold indefinitely.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, frog_x=START_X, frog_y=START_Y, facing=00, hopping=0, dead=0, hop_done=0, counters 0, edge registers 0, queue empty.
REQ-028 Reset asserted mid-HOP or mid-DEAD SHALL abandon the operation; no hop_done pulse SHALL occur.
REQ-029 A button held through reset release SHALL NOT count as a press.

Configuration
REQ-030 Macro FROG_HOP_QUEUE_EN defined: a press accepted during HOP SHALL be stored in a one-entry queue (a later press overwrites it); on return to IDLE, the queued press SHALL be handled as in REQ-020 on the following cycle; entering DEAD or reset SHALL clear the queue.
REQ-031 Macro FROG_HOP_QUEUE_EN undefined: presses during HOP SHALL be discarded; no queue storage SHALL exist.

Verification
REQ-032 After reset, press up with frame_tick every 4 cycles -> facing=00, frog_y steps 448,444,...,416 over 8 ticks, hop_done pulses once, then IDLE.
REQ-033 At x=0, press left -> facing=10, frog_x stays 0, hopping stays 0.
REQ-034 Assert hit on the 3rd tick of a right hop from x=304 -> dead=1, frog_x frozen at 316; after 60 ticks, x=304, y=448, facing=00.
REQ-035 Press up and right in the same cycle -> only the up hop occurs; facing=00.
REQ-036 With FROG_HOP_QUEUE_EN, press left mid-hop of up -> after hop_done, a left hop follows, ending at x=272, y=416; without the macro, the frog ends at x=304, y=416.
REQ-037 Pull rst_n low mid-HOP -> outputs return to reset values asynchronously; no hop_done pulse.

Source files
------------

// File: rtl/frog_move_ctrl.sv
// Frog hop controller: edge-detected buttons drive IDLE/HOP/DEAD motion; FROG_HOP_QUEUE_EN adds a one-entry hop queue.
// Latency: press seen on one edge moves the FSM on the next; hop spans HOP_FRAMES frame_ticks.
// Backpressure: none; presses outside IDLE are dropped (or queued in HOP when the queue is enabled).
module frog_move_ctrl #(
   parameter logic [9:0] START_X      = 10'd304,
   parameter logic [9:0] START_Y      = 10'd448,
   parameter logic [9:0] STEP         = 10'd32,
   parameter int         HOP_FRAMES   = 8,
   parameter logic [9:0] X_MAX        = 10'd608,
   parameter logic [9:0] Y_MAX        = 10'd448,
   parameter int         DEATH_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       frame_tick,
   input  logic       hit,
   output logic [9:0] frog_x,
   output logic [9:0] frog_y,
   output logic [1:0] facing,
   output logic       hopping,
   output logic       dead,
   output logic       hop_done
);

   localparam logic [9:0] DELTA   = STEP / 10'(HOP_FRAMES);
   localparam int         CNT_TOP = (HOP_FRAMES > DEATH_FRAMES) ? HOP_FRAMES : DEATH_FRAMES;
   localparam int         CW      = $clog2(CNT_TOP + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, HOP = 2'd1, DEAD = 2'd2} state_t;

   state_t        state, state_nxt;
   logic [3:0]    btn_lvl, btn_prev, rise;
   logic          armed;
   logic          press_vld, act_vld;
   logic [1:0]    press_dir, act_dir;
   logic [9:0]    x_nxt, y_nxt;
   logic [1:0]    facing_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          hop_done_nxt;

   // armed stays low for the first edge after reset so a held button is not a press
   assign btn_lvl = {btn_right, btn_left, btn_down, btn_up};
   assign rise    = armed ? (btn_lvl & ~btn_prev) : 4'b0000;

   always_comb begin
      press_vld = |rise;
      press_dir = 2'b00;
      if (rise[0])      press_dir = 2'b00;
      else if (rise[1]) press_dir = 2'b01;
      else if (rise[2]) press_dir = 2'b10;
      else if (rise[3]) press_dir = 2'b11;
   end

`ifdef FROG_HOP_QUEUE_EN
   logic       q_vld, q_vld_nxt;
   logic [1:0] q_dir, q_dir_nxt;

   assign act_vld = q_vld | press_vld;
   assign act_dir = q_vld ? q_dir : press_dir;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_vld <= 1'b0;
         q_dir <= 2'b00;
      end else begin
         q_vld <= q_vld_nxt;
         q_dir <= q_dir_nxt;
      end
   end
`else
   assign act_vld = press_vld;
   assign act_dir = press_dir;
`endif

   // Compare in 11 bits so the upper bound never wraps; lower bound checked before any subtract
   function automatic logic in_bounds(input logic [1:0] dir, input logic [9:0] x, input logic [9:0] y);
      logic [10:0] sum_x;
      logic [10:0] sum_y;
      sum_x = {1'b0, x} + {1'b0, STEP};
      sum_y = {1'b0, y} + {1'b0, STEP};
      case (dir)
         2'b00:   return y >= STEP;
         2'b01:   return sum_y <= {1'b0, Y_MAX};
         2'b10:   return x >= STEP;
         default: return sum_x <= {1'b0, X_MAX};
      endcase
   endfunction

   always_comb begin
      state_nxt    = state;
      x_nxt        = frog_x;
      y_nxt        = frog_y;
      facing_nxt   = facing;
      cnt_nxt      = cnt;
      hop_done_nxt = 1'b0;
`ifdef FROG_HOP_QUEUE_EN
      q_vld_nxt    = q_vld;
      q_dir_nxt    = q_dir;
`endif
      if (state != DEAD && hit) begin
         state_nxt = DEAD;
         cnt_nxt   = '0;
`ifdef FROG_HOP_QUEUE_EN
         q_vld_nxt = 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (act_vld) begin
                  facing_nxt = act_dir;
`ifdef FROG_HOP_QUEUE_EN
                  q_vld_nxt  = 1'b0;
`endif
                  if (in_bounds(act_dir, frog_x, frog_y)) begin
                     state_nxt = HOP;
                     cnt_nxt   = '0;
                  end
               end
            end
            HOP: begin
`ifdef FROG_HOP_QUEUE_EN
               if (press_vld) begin
                  q_vld_nxt = 1'b1;
                  q_dir_nxt = press_dir;
               end
`endif
               if (frame_tick) begin
                  case (facing)
                     2'b00:   y_nxt = frog_y - DELTA;
                     2'b01:   y_nxt = frog_y + DELTA;
                     2'b10:   x_nxt = frog_x - DELTA;
                     default: x_nxt = frog_x + DELTA;
                  endcase
                  if (cnt == CW'(HOP_FRAMES - 1)) begin
                     state_nxt    = IDLE;
                     cnt_nxt      = '0;
                     hop_done_nxt = 1'b1;
                  end else begin
                     cnt_nxt = cnt + CW'(1);
                  end
               end
            end
            DEAD: begin
               if (frame_tick) begin
                  if (cnt == CW'(DEATH_FRAMES - 1)) begin
                     state_nxt  = IDLE;
                     x_nxt      = START_X;
                     y_nxt      = START_Y;
                     facing_nxt = 2'b00;
                     cnt_nxt    = '0;
                  end else begin
                     cnt_nxt = cnt + CW'(1);
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         frog_x   <= START_X;
         frog_y   <= START_Y;
         facing   <= 2'b00;
         cnt      <= '0;
         hop_done <= 1'b0;
         btn_prev <= 4'b0000;
         armed    <= 1'b0;
      end else begin
         state    <= state_nxt;
         frog_x   <= x_nxt;
         frog_y   <= y_nxt;
         facing   <= facing_nxt;
         cnt      <= cnt_nxt;
         hop_done <= hop_done_nxt;
         btn_prev <= btn_lvl;
         armed    <= 1'b1;
      end
   end

   assign hopping = (state == HOP);
   assign dead    = (state == DEAD);

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Bench for frog_move_ctrl: directed scenarios plus a randomized run against a position-level model.
module tb_frog_move_ctrl;

   localparam int START_X = 304, START_Y = 448, STEP = 32, HOP_FRAMES = 8;
   localparam int X_MAX = 608, Y_MAX = 448, DEATH_FRAMES = 60;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       frame_tick = 1'b0, hit = 1'b0;
   logic [9:0] frog_x, frog_y;
   logic [1:0] facing;
   logic       hopping, dead, hop_done;

   int checks = 0;
   int errors = 0;

   frog_move_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .frame_tick (frame_tick),
      .hit        (hit),
      .frog_x     (frog_x),
      .frog_y     (frog_y),
      .facing     (facing),
      .hopping    (hopping),
      .dead       (dead),
      .hop_done   (hop_done)
   );

   always #5 clk = ~clk;

   // Reference model: position = origin + dir*STEP*k/HOP_FRAMES, death as a tick countdown
   int       m_x, m_y, m_face, m_ox, m_oy, m_k, m_dk, m_qdir;
   bit       m_hop, m_dead, m_done, m_armed, m_q;
   bit [3:0] m_prev;

   function automatic void m_reset();
      m_x = START_X; m_y = START_Y; m_face = 0; m_ox = 0; m_oy = 0; m_k = 0; m_dk = 0;
      m_qdir = 0; m_hop = 0; m_dead = 0; m_done = 0; m_armed = 0; m_q = 0; m_prev = 4'b0;
   endfunction

   function automatic int dx_of(input int d);
      return (d == 2) ? -1 : (d == 3) ? 1 : 0;
   endfunction

   function automatic int dy_of(input int d);
      return (d == 0) ? -1 : (d == 1) ? 1 : 0;
   endfunction

   function automatic void m_update();
      bit [3:0] lvl, rise;
      bit       pv, go;
      int       pdir, d, tx, ty;
      lvl     = {btn_right, btn_left, btn_down, btn_up};
      rise    = m_armed ? (lvl & ~m_prev) : 4'b0;
      m_prev  = lvl;
      m_armed = 1;
      pv      = (rise != 4'b0);
      pdir    = 0;
      for (int i = 3; i >= 0; i--) if (rise[i]) pdir = i;
      m_done  = 0;
      if (m_dead) begin
         if (frame_tick) begin
            m_dk++;
            if (m_dk == DEATH_FRAMES) begin
               m_dead = 0; m_x = START_X; m_y = START_Y; m_face = 0;
            end
         end
      end else if (hit) begin
         m_dead = 1; m_hop = 0; m_dk = 0; m_q = 0;
      end else if (m_hop) begin
`ifdef FROG_HOP_QUEUE_EN
         if (pv) begin m_q = 1; m_qdir = pdir; end
`endif
         if (frame_tick) begin
            m_k++;
            m_x = m_ox + dx_of(m_face) * STEP * m_k / HOP_FRAMES;
            m_y = m_oy + dy_of(m_face) * STEP * m_k / HOP_FRAMES;
            if (m_k == HOP_FRAMES) begin m_hop = 0; m_done = 1; end
         end
      end else begin
         go = 0; d = 0;
         if (m_q) begin go = 1; d = m_qdir; m_q = 0; end
         else if (pv) begin go = 1; d = pdir; end
         if (go) begin
            m_face = d;
            tx = m_x + dx_of(d) * STEP;
            ty = m_y + dy_of(d) * STEP;
            if (tx >= 0 && tx <= X_MAX && ty >= 0 && ty <= Y_MAX) begin
               m_hop = 1; m_k = 0; m_ox = m_x; m_oy = m_y;
            end
         end
      end
   endfunction

   task automatic clk_step();
      if (!rst_n) m_reset();
      else m_update();
      @(posedge clk);
      #1;
   endtask

   task automatic set_btns(input bit [3:0] v);
      {btn_right, btn_left, btn_down, btn_up} = v;
   endtask

   task automatic press(input int d);
      bit [3:0] v;
      v = 4'b0001;
      set_btns(v << d);
      clk_step();
      set_btns(4'b0000);
      clk_step();
   endtask

   task automatic do_hop(input int d);
      press(d);
      for (int i = 0; i < 40 && hopping; i++) begin
         frame_tick = 1'b1;
         clk_step();
      end
      frame_tick = 1'b0;
      clk_step();
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({frog_x, frog_y, facing, hopping, dead, hop_done} !== {10'd304, 10'd448, 2'b00, 3'b000}) begin
         errors++;
         $display("FAIL reset_state got x=%0d y=%0d f=%0d hop=%0d dead=%0d done=%0d exp 304 448 0 0 0 0",
                  frog_x, frog_y, facing, hopping, dead, hop_done);
      end
      btn_up = 1'b1;
      clk_step();
      clk_step();
      rst_n = 1'b1;
      repeat (3) clk_step();
      checks++;
      if ({hopping, frog_y} !== {1'b0, 10'd448}) begin
         errors++;
         $display("FAIL held_through_reset got hop=%0d y=%0d exp 0 448", hopping, frog_y);
      end
      btn_up = 1'b0;
      clk_step();
   endtask

   task automatic test_hop_up();
      int pulses;
      pulses = 0;
      btn_up = 1'b1;
      clk_step();
      btn_up = 1'b0;
      checks++;
      if ({hopping, facing} !== 3'b100) begin
         errors++;
         $display("FAIL hop_start got hop=%0d f=%0d exp 1 0", hopping, facing);
      end
      for (int i = 1; i <= 8; i++) begin
         frame_tick = 1'b1;
         clk_step();
         frame_tick = 1'b0;
         if (hop_done) pulses++;
         checks++;
         if ({frog_x, frog_y} !== {10'd304, 10'(448 - 4 * i)}) begin
            errors++;
            $display("FAIL hop_step%0d got x=%0d y=%0d exp 304 %0d", i, frog_x, frog_y, 448 - 4 * i);
         end
         if (i == 8) begin
            checks++;
            if ({hop_done, hopping} !== 2'b10) begin
               errors++;
               $display("FAIL hop_end got done=%0d hop=%0d exp 1 0", hop_done, hopping);
            end
         end
         for (int j = 0; j < 3; j++) begin
            clk_step();
            if (hop_done) pulses++;
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL hop_done_count got %0d exp 1", pulses);
      end
   endtask

   task automatic test_priority();
      set_btns(4'b1001);
      clk_step();
      set_btns(4'b0000);
      checks++;
      if ({hopping, facing} !== 3'b100) begin
         errors++;
         $display("FAIL prio_start got hop=%0d f=%0d exp 1 0", hopping, facing);
      end
      for (int i = 0; i < 40 && hopping; i++) begin
         frame_tick = 1'b1;
         clk_step();
      end
      frame_tick = 1'b0;
      clk_step();
      checks++;
      if ({frog_x, frog_y, facing} !== {10'd304, 10'd384, 2'b00}) begin
         errors++;
         $display("FAIL prio_end got x=%0d y=%0d f=%0d exp 304 384 0", frog_x, frog_y, facing);
      end
   endtask

   task automatic test_hit_hop();
      btn_right = 1'b1;
      clk_step();
      btn_right = 1'b0;
      for (int i = 0; i < 3; i++) begin
         frame_tick = 1'b1; clk_step();
         frame_tick = 1'b0; clk_step();
      end
      hit = 1'b1;
      clk_step();
      hit = 1'b0;
      checks++;
      if ({dead, hopping, hop_done, frog_x} !== {3'b100, 10'd316}) begin
         errors++;
         $display("FAIL hit_enter got dead=%0d hop=%0d done=%0d x=%0d exp 1 0 0 316", dead, hopping, hop_done, frog_x);
      end
      press(0);
      checks++;
      if ({dead, facing} !== 3'b111) begin
         errors++;
         $display("FAIL dead_ignores_press got dead=%0d f=%0d exp 1 3", dead, facing);
      end
      for (int k = 1; k <= 60; k++) begin
         frame_tick = 1'b1; clk_step();
         frame_tick = 1'b0; clk_step();
         if (k < 60) begin
            checks++;
            if ({dead, frog_x} !== {1'b1, 10'd316}) begin
               errors++;
               $display("FAIL dead_hold%0d got dead=%0d x=%0d exp 1 316", k, dead, frog_x);
            end
         end
      end
      checks++;
      if ({dead, frog_x, frog_y, facing} !== {1'b0, 10'd304, 10'd448, 2'b00}) begin
         errors++;
         $display("FAIL respawn got dead=%0d x=%0d y=%0d f=%0d exp 0 304 448 0", dead, frog_x, frog_y, facing);
      end
   endtask

   task automatic test_bounds();
      press(1);
      checks++;
      if ({facing, hopping, frog_y} !== {2'b01, 1'b0, 10'd448}) begin
         errors++;
         $display("FAIL bound_down got f=%0d hop=%0d y=%0d exp 1 0 448", facing, hopping, frog_y);
      end
      for (int i = 0; i < 9; i++) do_hop(2);
      press(2);
      checks++;
      if ({facing, hopping, frog_x} !== {2'b10, 1'b0, 10'd16}) begin
         errors++;
         $display("FAIL bound_left got f=%0d hop=%0d x=%0d exp 2 0 16", facing, hopping, frog_x);
      end
      for (int i = 0; i < 14; i++) do_hop(0);
      press(0);
      checks++;
      if ({facing, hopping, frog_y} !== {2'b00, 1'b0, 10'd0}) begin
         errors++;
         $display("FAIL bound_up got f=%0d hop=%0d y=%0d exp 0 0 0", facing, hopping, frog_y);
      end
      for (int i = 0; i < 18; i++) do_hop(3);
      press(3);
      checks++;
      if ({facing, hopping, frog_x} !== {2'b11, 1'b0, 10'd592}) begin
         errors++;
         $display("FAIL bound_right got f=%0d hop=%0d x=%0d exp 3 0 592", facing, hopping, frog_x);
      end
   endtask

   task automatic test_queue();
      int exp_x;
`ifdef FROG_HOP_QUEUE_EN
      exp_x = 272;
`else
      exp_x = 304;
`endif
      rst_n = 1'b0;
      m_reset();
      clk_step();
      rst_n = 1'b1;
      clk_step();
      btn_up = 1'b1; clk_step(); btn_up = 1'b0;
      for (int i = 0; i < 3; i++) begin
         frame_tick = 1'b1; clk_step();
         frame_tick = 1'b0; clk_step();
      end
      btn_left = 1'b1; clk_step(); btn_left = 1'b0; clk_step();
      frame_tick = 1'b1;
      repeat (40) clk_step();
      frame_tick = 1'b0;
      repeat (2) clk_step();
      checks++;
      if ({frog_x, frog_y, hopping} !== {10'(exp_x), 10'd416, 1'b0}) begin
         errors++;
         $display("FAIL queue_end got x=%0d y=%0d hop=%0d exp %0d 416 0", frog_x, frog_y, hopping, exp_x);
      end
   endtask

   task automatic test_reset_mid_hop();
      int pulses;
      pulses = 0;
      btn_down = 1'b1; clk_step(); btn_down = 1'b0;
      for (int i = 0; i < 3; i++) begin
         frame_tick = 1'b1; clk_step();
         frame_tick = 1'b0; clk_step();
      end
      checks++;
      if (hopping !== 1'b1) begin
         errors++;
         $display("FAIL midhop_active got hop=%0d exp 1", hopping);
      end
      rst_n = 1'b0;
      #1;
      m_reset();
      checks++;
      if ({frog_x, frog_y, facing, hopping, dead, hop_done} !== {10'd304, 10'd448, 2'b00, 3'b000}) begin
         errors++;
         $display("FAIL midhop_reset got x=%0d y=%0d f=%0d hop=%0d dead=%0d done=%0d exp 304 448 0 0 0 0",
                  frog_x, frog_y, facing, hopping, dead, hop_done);
      end
      frame_tick = 1'b1;
      repeat (2) begin clk_step(); if (hop_done) pulses++; end
      rst_n = 1'b1;
      repeat (12) begin clk_step(); if (hop_done) pulses++; end
      frame_tick = 1'b0;
      checks++;
      if ({pulses != 0, hopping, frog_y} !== {2'b00, 10'd448}) begin
         errors++;
         $display("FAIL midhop_no_done got pulses=%0d hop=%0d y=%0d exp 0 0 448", pulses, hopping, frog_y);
      end
   endtask

   task automatic test_random();
      bit [3:0] lvl;
      lvl = 4'b0;
      for (int n = 0; n < 4000; n++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 15) == 0) lvl[b] = ~lvl[b];
         set_btns(lvl);
         frame_tick = ($urandom_range(0, 2) == 0);
         hit        = ($urandom_range(0, 249) == 0);
         rst_n      = ($urandom_range(0, 1999) != 0);
         clk_step();
         checks++;
         if ({frog_x, frog_y, facing, hopping, dead, hop_done} !==
             {10'(m_x), 10'(m_y), 2'(m_face), m_hop, m_dead, m_done}) begin
            errors++;
            if (errors < 20)
               $display("FAIL random@%0d got x=%0d y=%0d f=%0d h=%0d d=%0d done=%0d exp %0d %0d %0d %0d %0d %0d",
                        n, frog_x, frog_y, facing, hopping, dead, hop_done,
                        m_x, m_y, m_face, m_hop, m_dead, m_done);
         end
      end
      set_btns(4'b0);
      frame_tick = 1'b0;
      hit = 1'b0;
      rst_n = 1'b1;
      clk_step();
   endtask

   initial begin
      m_reset();
      test_reset();
      test_hop_up();
      test_priority();
      test_hit_hop();
      test_bounds();
      test_queue();
      test_reset_mid_hop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
